spi_frame_master: RTL and testbench

Parametrised SPI write master for the board's DAC and converter configuration ports, replacing fixed-table, fixed-timing SPI writers.
- Frames of FRAME_BITS, taken one at a time from a valid/ready word interface, driven MSB-first to one or more chip selects.
- Programmable SCLK rate, CS setup/hold/idle timing and clock polarity.
- Sits between a configuration sequencer (ROM walker or host register bank) and the device pins.

---
 rtl/spi_frame_master.sv | 175 +++++++++++++++++
 tb/tb_spi_frame_master.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_master.sv
// SPI write master: one FRAME_BITS word per frame, MSB first, multi-hot chip selects.
// Latency: cs_n asserts the cycle after accept; done pulses CS_SETUP+2*FRAME_BITS*CLK_DIV+CS_HOLD cycles later.
// Backpressure: tx_ready is low from accept until CS_IDLE cycles after done; tx_valid is ignored meanwhile.
//
// Optional build macro: SPI_READBACK_EN. When defined, miso is captured on every leading
// SCLK edge and presented on rx_data with an rx_valid pulse alongside done. When undefined,
// rx_data and rx_valid are held at zero and miso is ignored.
//
// Ports:
//   clk, rst             system clock, synchronous active-low reset
//   tx_data, tx_cs_sel   frame word and chip-select mask, taken on tx_valid && tx_ready
//   tx_valid, tx_ready   word handshake
//   busy, done           frame in flight / one-cycle pulse as cs_n deasserts
//   cs_n, sclk, mosi     SPI pins out
//   miso                 SPI data in (readback builds only)
//   rx_data, rx_valid    captured readback word and its one-cycle strobe
module spi_frame_master #(
    parameter int FRAME_BITS = 24,
    parameter int NUM_CS     = 1,
    parameter int CLK_DIV    = 16,
    parameter int CS_SETUP   = 4,
    parameter int CS_HOLD    = 4,
    parameter int CS_IDLE    = 8,
    parameter bit CPOL       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic [NUM_CS-1:0]     tx_cs_sel,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_CS-1:0]     cs_n,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    // One shared cycle counter; sized for the longest span it could ever be asked to hold.
    localparam int MAX_CNT = 2*FRAME_BITS*CLK_DIV + CS_SETUP + CS_HOLD + CS_IDLE;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int EW      = $clog2(2*FRAME_BITS);

    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(CS_IDLE - 1);
    localparam logic [EW-1:0] EDGE_LAST  = EW'(2*FRAME_BITS - 1);

    logic [2:0]            state;
    logic [CW-1:0]         cnt;
    logic [EW-1:0]         ecnt;   // SCLK toggle index within the frame; even = leading edge
    logic [FRAME_BITS-2:0] sh;     // bits still to send; the current bit already sits on mosi

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ecnt     <= '0;
            sh       <= '0;
            cs_n     <= '1;
            sclk     <= CPOL;
            mosi     <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        cs_n     <= ~tx_cs_sel;
                        mosi     <= tx_data[FRAME_BITS-1];
                        sh       <= tx_data[FRAME_BITS-2:0];
                        cnt      <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        ecnt  <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == HALF_LAST) begin
                        cnt  <= '0;
                        sclk <= ~sclk;
                        ecnt <= ecnt + 1'b1;
                        if (ecnt == EDGE_LAST) begin
                            // Final trailing edge: no further bit, park mosi low.
                            mosi  <= 1'b0;
                            state <= HOLD;
                        end else if (ecnt[0]) begin
                            mosi <= sh[FRAME_BITS-2];
                            sh   <= {sh[FRAME_BITS-3:0], 1'b0};
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        cs_n  <= '1;
                        done  <= 1'b1;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt      <= '0;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic [FRAME_BITS-1:0] rx_sh;

    // miso is taken on the same clk edge that raises the leading SCLK edge, so it pairs
    // with the bit the target is sampling at that moment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state == SHIFT && cnt == HALF_LAST && !ecnt[0]) begin
                rx_sh <= {rx_sh[FRAME_BITS-2:0], miso};
            end
            if (state == HOLD && cnt == HOLD_LAST) begin
                rx_data  <= rx_sh;
                rx_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_miso;
    assign unused_miso = miso;

    always_ff @(posedge clk) begin
        rx_data  <= '0;
        rx_valid <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_spi_frame_master.sv
module tb_spi_frame_master;

    localparam int LIM = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- u0: default parameters, miso looped from mosi ----------------
    logic [23:0] tx_data0;
    logic [0:0]  tx_sel0;
    logic        tx_valid0, tx_ready0, busy0, done0, sclk0, mosi0, rx_valid0;
    logic [0:0]  cs_n0;
    logic [23:0] rx_data0;

    spi_frame_master u0 (
        .clk(clk), .rst(rst0), .tx_data(tx_data0), .tx_cs_sel(tx_sel0),
        .tx_valid(tx_valid0), .tx_ready(tx_ready0), .busy(busy0), .done(done0),
        .cs_n(cs_n0), .sclk(sclk0), .mosi(mosi0), .miso(mosi0),
        .rx_data(rx_data0), .rx_valid(rx_valid0)
    );

    // ---------------- u1: four chip selects ----------------
    logic [23:0] tx_data1;
    logic [3:0]  tx_sel1;
    logic        tx_valid1, tx_ready1, busy1, done1, sclk1, mosi1, rx_valid1;
    logic [3:0]  cs_n1;
    logic [23:0] rx_data1;

    spi_frame_master #(.NUM_CS(4)) u1 (
        .clk(clk), .rst(rst1), .tx_data(tx_data1), .tx_cs_sel(tx_sel1),
        .tx_valid(tx_valid1), .tx_ready(tx_ready1), .busy(busy1), .done(done1),
        .cs_n(cs_n1), .sclk(sclk1), .mosi(mosi1), .miso(1'b0),
        .rx_data(rx_data1), .rx_valid(rx_valid1)
    );

    // ---------------- u2: CPOL=1, fast clock, 16-bit frames ----------------
    logic [15:0] tx_data2;
    logic [0:0]  tx_sel2;
    logic        tx_valid2, tx_ready2, busy2, done2, sclk2, mosi2, rx_valid2;
    logic [0:0]  cs_n2;
    logic [15:0] rx_data2;

    spi_frame_master #(.FRAME_BITS(16), .CLK_DIV(2), .CPOL(1'b1)) u2 (
        .clk(clk), .rst(rst1), .tx_data(tx_data2), .tx_cs_sel(tx_sel2),
        .tx_valid(tx_valid2), .tx_ready(tx_ready2), .busy(busy2), .done(done2),
        .cs_n(cs_n2), .sclk(sclk2), .mosi(mosi2), .miso(1'b0),
        .rx_data(rx_data2), .rx_valid(rx_valid2)
    );

    // ---------------- scoreboards ----------------
    typedef struct { logic [23:0] d; bit gapchk; } exp0_t;
    typedef struct { logic [23:0] d; logic [3:0] sel; } exp1_t;
    exp0_t       q0[$];
    exp1_t       q1[$];
    logic [15:0] q2[$];

    // u0 monitor
    exp0_t       e0;
    logic        prev_sclk0 = 1'b0;
    logic        prev_cs0 = 1'b1;
    logic [23:0] cap0 = '0;
    int          edges0 = 0, low0 = 0, hi0 = 0, rw0 = 0, stray0 = 0;
    bit          rw_act0 = 1'b0;

    always @(negedge clk) begin
        if (rst0) begin
            if (!cs_n0[0]) begin
                if (prev_cs0 && q0.size() > 0 && q0[0].gapchk)
                    check("gap_cs_high_cycles", hi0, 9);
                low0++;
            end
            if (sclk0 && !prev_sclk0) begin
                cap0 = {cap0[22:0], mosi0};
                edges0++;
            end
            if (rx_valid0 && !done0) stray0++;
            if (done0) begin
                check("done_expected", q0.size() > 0, 1);
                if (q0.size() > 0) begin
                    e0 = q0.pop_front();
                    check("u0_frame_data", cap0, e0.d);
                    check("u0_rise_edges", edges0, 24);
                    check("u0_cs_low_cycles", low0, 776);
                    check("done_at_cs_rise", {prev_cs0, cs_n0[0]}, 2'b01);
                    check("busy_at_done", busy0, 1);
`ifdef SPI_READBACK_EN
                    check("rx_valid_with_done", rx_valid0, 1);
                    check("rx_data", rx_data0, e0.d);
`else
                    check("rx_valid_off", rx_valid0, 0);
                    check("rx_data_off", rx_data0, 0);
`endif
                end
                rw0 = 0;
                rw_act0 = 1'b1;
                hi0 = 0;
            end else if (rw_act0) begin
                rw0++;
                if (tx_ready0) begin
                    check("ready_after_done", rw0, 8);
                    check("busy_clear", busy0, 0);
                    rw_act0 = 1'b0;
                end
            end
            if (cs_n0[0]) begin
                hi0++;
                low0 = 0;
                edges0 = 0;
            end
        end else begin
            edges0 = 0;
            low0 = 0;
            rw_act0 = 1'b0;
        end
        prev_sclk0 = sclk0;
        prev_cs0 = cs_n0[0];
    end

    // u1 monitor
    exp1_t       e1;
    logic        prev_sclk1 = 1'b0;
    logic [3:0]  lowseen1 = '0;
    logic [23:0] cap1 = '0;

    always @(negedge clk) begin
        if (rst1) begin
            lowseen1 = lowseen1 | ~cs_n1;
            if (sclk1 && !prev_sclk1) cap1 = {cap1[22:0], mosi1};
            if (done1) begin
                check("u1_done_expected", q1.size() > 0, 1);
                if (q1.size() > 0) begin
                    e1 = q1.pop_front();
                    check("u1_cs_pattern", lowseen1, e1.sel);
                    check("u1_frame_data", cap1, e1.d);
                end
                lowseen1 = '0;
            end
        end
        prev_sclk1 = sclk1;
    end

    // u2 monitor: leading edges are falling edges
    logic [15:0] e2;
    logic        prev_sclk2 = 1'b1;
    logic [15:0] cap2 = '0;
    int          low2 = 0, fall2 = 0;

    always @(negedge clk) begin
        if (rst1) begin
            if (!cs_n2[0]) low2++;
            if (!sclk2 && prev_sclk2) begin
                cap2 = {cap2[14:0], mosi2};
                fall2++;
            end
            if (done2) begin
                check("u2_done_expected", q2.size() > 0, 1);
                if (q2.size() > 0) begin
                    e2 = q2.pop_front();
                    check("u2_frame_data", cap2, e2);
                    check("u2_fall_edges", fall2, 16);
                    check("u2_cs_low_cycles", low2, 72);
                    check("u2_sclk_idle_high", sclk2, 1);
                end
                low2 = 0;
                fall2 = 0;
            end
        end
        prev_sclk2 = sclk2;
    end

    // ---------------- stimulus helpers (called on a negedge) ----------------
    task automatic send0(input logic [23:0] d, input bit keep, input bit gap, input bit push);
        int n = 0;
        tx_data0 = d;
        tx_sel0 = 1'b1;
        tx_valid0 = 1'b1;
        while (!tx_ready0 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        check("u0_accept_wait", n < LIM, 1);
        if (push) q0.push_back('{d, gap});
        @(negedge clk);
        if (!keep) tx_valid0 = 1'b0;
    endtask

    task automatic wait0();
        int n = 0;
        while (!(q0.size() == 0 && tx_ready0) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        check("u0_frame_wait", n < LIM, 1);
    endtask

    task automatic send1(input logic [23:0] d, input logic [3:0] s);
        int n = 0;
        tx_data1 = d;
        tx_sel1 = s;
        tx_valid1 = 1'b1;
        while (!tx_ready1 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        check("u1_accept_wait", n < LIM, 1);
        q1.push_back('{d, s});
        @(negedge clk);
        tx_valid1 = 1'b0;
        n = 0;
        while (!(q1.size() == 0 && tx_ready1) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        check("u1_frame_wait", n < LIM, 1);
    endtask

    task automatic send2(input logic [15:0] d);
        int n = 0;
        tx_data2 = d;
        tx_sel2 = 1'b1;
        tx_valid2 = 1'b1;
        while (!tx_ready2 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        check("u2_accept_wait", n < LIM, 1);
        q2.push_back(d);
        @(negedge clk);
        tx_valid2 = 1'b0;
        n = 0;
        while (!(q2.size() == 0 && tx_ready2) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        check("u2_frame_wait", n < LIM, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst0 = 1'b0;
        rst1 = 1'b0;
        tx_data0 = '0; tx_sel0 = '0; tx_valid0 = 1'b0;
        tx_data1 = '0; tx_sel1 = '0; tx_valid1 = 1'b0;
        tx_data2 = '0; tx_sel2 = '0; tx_valid2 = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_cs_n", cs_n0, 1);
        check("rst_sclk", sclk0, 0);
        check("rst_mosi", mosi0, 0);
        check("rst_tx_ready", tx_ready0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_rx_data", rx_data0, 0);
        check("rst_rx_valid", rx_valid0, 0);
        check("rst_u1_cs_n", cs_n1, 4'hF);
        check("rst_u2_sclk_cpol", sclk2, 1);

        rst0 = 1'b1;
        rst1 = 1'b1;
        @(negedge clk);
        check("ready_after_reset", tx_ready0, 1);

        fork
            begin
                // single frame
                send0(24'h000D04, 1'b0, 1'b0, 1'b1);
                wait0();
                // back-to-back with tx_valid held high
                send0(24'h001531, 1'b1, 1'b0, 1'b1);
                send0(24'h002134, 1'b0, 1'b1, 1'b1);
                wait0();
                // abort mid-frame after the 10th leading edge
                begin
                    int n = 0;
                    send0(24'h00AAAA, 1'b0, 1'b0, 1'b0);
                    while (edges0 < 10 && n < LIM) begin
                        @(negedge clk);
                        n++;
                    end
                    check("abort_edge_wait", n < LIM, 1);
                    rst0 = 1'b0;
                    @(negedge clk);
                    check("abort_cs_n", cs_n0, 1);
                    check("abort_sclk", sclk0, 0);
                    check("abort_done", done0, 0);
                    rst0 = 1'b1;
                    @(negedge clk);
                    check("ready_after_abort", tx_ready0, 1);
                end
                send0(24'h001606, 1'b0, 1'b0, 1'b1);
                wait0();
                // readback word (loopback)
                send0(24'hC3A501, 1'b0, 1'b0, 1'b1);
                wait0();
            end
            begin
                send1(24'h001804, 4'b1010);
                send1(24'h00ABCD, 4'b0000);
            end
            begin
                send2(16'hA55A);
            end
        join

        repeat (20) @(negedge clk);
        check("rx_valid_without_done", stray0, 0);
        check("u0_queue_drained", q0.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
